// File: rtl/cell_bist_pkg.sv
// Shared constants for the 3-input cell BIST controller: FSM state encoding,
// the reference NAND3 truth table and counter widths.
package cell_bist_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_APPLY  = 3'd1,
    S_SETTLE = 3'd2,
    S_SAMPLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // Bit i is the expected ZN for pattern index i = {A1,A2,A3}.
  localparam logic [7:0] NAND3_TRUTH = 8'h7F;

  localparam int         CNT_W    = 4;
  localparam logic [3:0] ERR_MAX  = 4'd8;
  localparam logic [2:0] LAST_IDX = 3'd7;

endpackage

// File: rtl/cell_bist_timer.sv
// Settle down-counter: loaded once per pattern, counts while enabled and
// pulses o_expire in the last counting cycle.
module cell_bist_timer
  import cell_bist_pkg::*;
(
  input  logic             CK,
  input  logic             RN,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_count,
  output logic             o_expire
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_count && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // A load of N gives exactly N enabled cycles, the last one with r_cnt==1.
  assign o_expire = i_count && (r_cnt == CNT_W'(1));

endmodule

// File: rtl/cell_bist_ctrl.sv
// BIST controller for a 3-input cell: walks patterns 000..111, holds each for
// SETTLE_CYCLES, samples ZN against TRUTH and accumulates a failure map.
module cell_bist_ctrl
  import cell_bist_pkg::*;
#(
  parameter int         SETTLE_CYCLES = 2,   // legal range 1..15
  parameter logic [7:0] TRUTH         = NAND3_TRUTH
)(
  input  logic       CK,
  input  logic       RN,
  input  logic       start,
  input  logic       abort,
  output logic       A1,
  output logic       A2,
  output logic       A3,
  input  logic       ZN,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] fail_vec,
  output logic [3:0] err_cnt,
  output state_t     dbg_state
);

  // start and abort are level commands sampled on each rising edge; there is
  // no handshake: start is honoured only in IDLE/DONE, abort only while busy,
  // and abort wins when both are high.
  state_t     r_state;
  logic [2:0] r_idx;
  logic [2:0] r_a;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [7:0] r_fail_vec;
  logic [3:0] r_err_cnt;

  logic       w_expire;
  logic       w_mismatch;
  logic       w_in_run;
  logic [7:0] w_fail_next;

  cell_bist_timer u_timer (
    .CK         (CK),
    .RN         (RN),
    .i_load     (r_state == S_APPLY),
    .i_load_val (CNT_W'(SETTLE_CYCLES)),
    .i_count    (r_state == S_SETTLE),
    .o_expire   (w_expire)
  );

  // Case inequality so an X/Z response is never mistaken for a match.
  assign w_mismatch = (ZN !== TRUTH[r_idx]);
  assign w_in_run   = (r_state == S_APPLY) || (r_state == S_SETTLE) ||
                      (r_state == S_SAMPLE);

  always_comb begin
    w_fail_next        = r_fail_vec;
    w_fail_next[r_idx] = r_fail_vec[r_idx] | w_mismatch;
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_a        <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_fail_vec <= '0;
      r_err_cnt  <= '0;
    end else if (w_in_run && abort) begin
      // Partial fail_vec/err_cnt are kept for post-mortem.
      r_state <= S_IDLE;
      r_a     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start && !abort) begin
            r_state    <= S_APPLY;
            r_idx      <= '0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_fail_vec <= '0;
            r_err_cnt  <= '0;
          end
        end
        S_APPLY: begin
          r_a     <= r_idx;
          r_state <= S_SETTLE;
        end
        S_SETTLE: begin
          if (w_expire) r_state <= S_SAMPLE;
        end
        S_SAMPLE: begin
          r_fail_vec <= w_fail_next;
          if (w_mismatch && (r_err_cnt != ERR_MAX)) r_err_cnt <= r_err_cnt + 4'd1;
          if (r_idx == LAST_IDX) begin
            r_state <= S_DONE;
            r_a     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_fail_next == 8'h00);
          end else begin
            r_idx   <= r_idx + 3'd1;
            r_state <= S_APPLY;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_a     <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign A1        = r_a[2];
  assign A2        = r_a[1];
  assign A3        = r_a[0];
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign fail_vec  = r_fail_vec;
  assign err_cnt   = r_err_cnt;
  assign dbg_state = r_state;

endmodule
